// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Holds the FSM state encoding, register indices and STATUS bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered pointers and a combinational head output.
// A push while full is accepted only when a pop happens in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_slave.sv
// Bus slave UART transmitter: register decode, TX FIFO and an 8N1 serializer
// whose bit period is BAUD_DIV+1 clocks, latched per frame at pop time.
module uart_tx_slave
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t           state_q, state_n;
    logic [DIV_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [2:0]       idx_q, idx_n;
    logic [7:0]       shift_q, shift_n;
    logic             tx_q, tx_n;

    logic [DIV_W-1:0] baud_div;
    logic             enable;
    logic             overflow;

    logic             push, pop, full, empty, start_ok;
    logic [7:0]       head;
    logic [CW-1:0]    count;
    logic [3:0]       cnt_disp;
    logic             unused_wdata;

    assign push         = ce && wr_en && (addr == REG_TXDATA);
    assign start_ok     = enable && !empty;
    assign tx           = tx_q;
    assign unused_wdata = ^wdata;

    fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // tx_n is the line level for the coming cycle, so tx leaves a flop.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        div_n   = div_q;
        idx_n   = idx_q;
        shift_n = shift_q;
        tx_n    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (start_ok) begin
                    pop     = 1'b1;
                    shift_n = head;
                    cnt_n   = baud_div;
                    div_n   = baud_div;
                    tx_n    = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_n   = div_q;
                    idx_n   = 3'd0;
                    tx_n    = shift_q[0];
                    state_n = ST_DATA;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_n = div_q;
                    if (idx_q == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = ST_STOP;
                    end else begin
                        idx_n   = idx_q + 1'b1;
                        shift_n = shift_q >> 1;
                        tx_n    = shift_q[1];
                    end
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (start_ok) begin
                        pop     = 1'b1;
                        shift_n = head;
                        cnt_n   = baud_div;
                        div_n   = baud_div;
                        tx_n    = 1'b0;
                        state_n = ST_START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            div_q   <= div_n;
            idx_q   <= idx_n;
            shift_q <= shift_n;
            tx_q    <= tx_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_div <= DIV_W'(DEFAULT_DIV);
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (ce && wr_en) begin
                case (addr)
                    REG_BAUD:   baud_div <= wdata[DIV_W-1:0];
                    REG_CTRL:   enable   <= wdata[0];
                    REG_STATUS: if (wdata[STAT_OVF]) overflow <= 1'b0;
                    default:    ;
                endcase
            end
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_comb begin
        cnt_disp = (32'(count) > 15) ? 4'hF : 4'(count);
    end

    always_comb begin
        rdata = '0;
        if (ce) begin
            case (addr)
                REG_STATUS: begin
                    rdata[STAT_FULL]                  = full;
                    rdata[STAT_EMPTY]                 = empty;
                    rdata[STAT_BUSY]                  = (state_q != ST_IDLE);
                    rdata[STAT_OVF]                   = overflow;
                    rdata[STAT_CNT_LSB+3:STAT_CNT_LSB] = cnt_disp;
                end
                REG_BAUD: rdata[DIV_W-1:0] = baud_div;
                REG_CTRL: rdata[0]         = enable;
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Self-checking bench for uart_tx_slave: a line-level receiver model decodes
// frames and compares them against bytes queued by the stimulus.
module tb_uart_tx_slave;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;

    int checks   = 0;
    int failures = 0;
    int tb_div   = 99;
    logic [7:0] exp_q[$];

    localparam logic [1:0] A_TX = 2'd0, A_ST = 2'd1, A_BD = 2'd2, A_CT = 2'd3;

    uart_tx_slave dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        ce = 1'b0; wr_en = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; wr_en = 1'b0; addr = a;
        #1;
        d = rdata;
        ce = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(A_TX, {24'h0, b});
    endtask

    task automatic wait_drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            ce = 1'b1; wr_en = 1'b0; addr = A_ST;
            #1;
            if (exp_q.size() == 0 && !rdata[2] && rdata[1]) done = 1'b1;
            ce = 1'b0;
        end
        check("drain_done", done, 1'b1);
    endtask

    // Expected line level k cycles after the edge that wrote the first byte:
    // frames of 10 bits (start, 8 data LSB first, stop) back to back from k=1.
    function automatic logic wave_bit(input int k, input int p, input logic [7:0] b0,
                                      input logic [7:0] b1, input int nf);
        int idx, f, j;
        logic [7:0] b;
        if (k < 1) return 1'b1;
        idx = (k - 1) / p;
        f   = idx / 10;
        j   = idx % 10;
        if (f >= nf) return 1'b1;
        b = (f == 0) ? b0 : b1;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Receiver monitor: on a falling edge, sample every cycle of 10 bit periods.
    initial begin : monitor
        logic prev, smp, ok, aborted;
        logic [9:0] bits;
        int p;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b1;
            end else if (prev && !tx) begin
                p = tb_div + 1;
                bits = '0;
                ok = 1'b1;
                aborted = 1'b0;
                for (int n = 1; n < 10 * p; n++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp = tx;
                    if (n % p == 0) bits[n / p] = smp;
                    else if (smp !== bits[n / p]) ok = 1'b0;
                end
                if (aborted) begin
                    prev = 1'b1;
                end else begin
                    prev = bits[9];
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_unexpected: got frame %0h expected none", bits[8:1]);
                    end else begin
                        check("rx_byte", bits[8:1], exp_q.pop_front());
                        check("rx_framing", {bits[0] == 1'b0, bits[9] == 1'b1, ok}, 3'b111);
                    end
                end
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : stim
        logic [31:0] rd;
        logic [127:0] act_w, exp_w;
        logic b100, b101, stuck;
        int d, n;

        reset = 1'b1; ce = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset_tx", tx, 1'b1);
        bus_read(A_ST, rd); check("reset_status", rd, 32'h2);
        bus_read(A_BD, rd); check("reset_baud", rd, 32'd99);
        bus_read(A_CT, rd); check("reset_ctrl", rd, 32'h1);
        bus_read(A_TX, rd); check("txdata_reads0", rd, 32'h0);

        // Exact waveform of one frame, BAUD_DIV=9
        bus_write(A_BD, 32'd9); tb_div = 9;
        push_byte(8'h55);
        ce = 1'b1; wr_en = 1'b0; addr = A_ST;
        act_w = '0; exp_w = '0; b100 = 1'b0; b101 = 1'b1;
        for (int k = 0; k <= 101; k++) begin
            @(negedge clk);
            act_w[k] = tx;
            exp_w[k] = wave_bit(k, 10, 8'h55, 8'h00, 1);
            if (k == 100) b100 = rdata[2];
            if (k == 101) b101 = rdata[2];
        end
        ce = 1'b0;
        check("wave_55", act_w, exp_w);
        check("busy_at_100", b100, 1'b1);
        check("busy_at_101", b101, 1'b0);
        wait_drain(50);

        // Back-to-back frames at BAUD_DIV=0
        bus_write(A_BD, 32'd0); tb_div = 0;
        push_byte(8'hA3);
        push_byte(8'h0F);
        act_w = '0; exp_w = '0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            act_w[k] = tx;
            exp_w[k] = wave_bit(k, 1, 8'hA3, 8'h0F, 2);
        end
        check("wave_b2b", act_w, exp_w);
        wait_drain(50);

        // Overflow with transmitter disabled
        bus_write(A_BD, 32'd1); tb_div = 1;
        bus_write(A_CT, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            bus_write(A_TX, 32'(i));
        end
        stuck = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) stuck = 1'b1;
        end
        check("tx_idle_disabled", stuck, 1'b0);
        bus_read(A_ST, rd); check("status_full_ovf", rd, 32'h89);
        bus_write(A_ST, 32'hF7);
        bus_read(A_ST, rd); check("status_w1c_ignored", rd, 32'h89);
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, rd); check("status_ovf_cleared", rd, 32'h81);
        bus_write(A_CT, 32'h1);
        wait_drain(400);
        bus_read(A_ST, rd); check("status_after_drain", rd, 32'h2);

        // Clearing enable mid-frame finishes that frame and keeps the rest
        bus_write(A_BD, 32'd2); tb_div = 2;
        push_byte(8'h3C);
        push_byte(8'hC3);
        bus_write(A_CT, 32'h0);
        stuck = 1'b1;
        for (int i = 0; i < 100 && stuck; i++) begin
            bus_read(A_ST, rd);
            if (exp_q.size() == 1 && !rd[2]) stuck = 1'b0;
        end
        check("enable_hold_done", stuck, 1'b0);
        bus_read(A_ST, rd); check("status_held_one", rd, 32'h10);
        bus_write(A_CT, 32'h1);
        wait_drain(100);

        // Randomised traffic
        for (int r = 0; r < 6; r++) begin
            d = $urandom_range(0, 4);
            bus_write(A_BD, 32'(d)); tb_div = d;
            bus_read(A_BD, rd); check("baud_readback", rd, 32'(d));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
            wait_drain(500);
        end

        // Reset in the middle of data bit 3 (0xA5 bit 3 is 0)
        bus_write(A_BD, 32'd9); tb_div = 9;
        push_byte(8'hA5);
        repeat (46) @(negedge clk);
        check("tx_before_reset", tx, 1'b0);
        #2;
        reset = 1'b1;
        exp_q.delete();
        tb_div = 99;
        #1;
        check("tx_async_reset", tx, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_ST, rd); check("status_after_reset", rd, 32'h2);
        bus_read(A_BD, rd); check("baud_after_reset", rd, 32'd99);
        stuck = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) stuck = 1'b1;
        end
        check("no_residual_frame", stuck, 1'b0);

        // Chip enable low: no push, rdata forced to 0
        @(negedge clk);
        ce = 1'b0; wr_en = 1'b1; addr = A_TX; wdata = 32'h77;
        #1;
        check("rdata_ce0_tx", rdata, 32'h0);
        @(posedge clk);
        #1;
        wr_en = 1'b0; addr = A_BD;
        #1;
        check("rdata_ce0_baud", rdata, 32'h0);
        bus_read(A_ST, rd); check("status_no_push", rd, 32'h2);
        stuck = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) stuck = 1'b1;
        end
        check("tx_idle_ce0", stuck, 1'b0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_slave.md
Name: uart_tx_slave

Overview:
Memory-mapped UART transmitter on the RV32I data bus, attached as slave 2 of the bus interconnect alongside RAM (slave 0) and GPO (slave 1).
- Chip enable comes from slave_sel[2]; rdata feeds the interconnect's slave_rdata3 input.
- CPU stores bytes into a TX FIFO. An 8N1 serializer drains the FIFO at a programmable bit period.
- Runs on the same clock as the CPU core and bus.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
DIV_W, 16, width of the baud divisor register.
DEFAULT_DIV, 99, reset value of BAUD_DIV; bit period = BAUD_DIV+1 clk cycles.

Ports:
clk  input  1  bus clock; all logic on posedge.
reset  input  1  asynchronous, active-high reset.
ce  input  1  chip enable from interconnect (slave_sel[2]).
wr_en  input  1  write strobe; a write occurs when ce && wr_en at posedge.
addr  input  2  register index (bus address bits [3:2]).
wdata  input  32  write data.
rdata  output  32  read data, combinational; 0 when ce=0.
tx  output  1  serial line, idle high.

Behaviour:
- Register map by addr:
  - 0 TXDATA: write pushes wdata[7:0] into the FIFO; reads 0.
  - 1 STATUS (read-only except W1C): [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [7:4] FIFO count, saturating display at 15; other bits 0.
  - 2 BAUD_DIV: R/W, wdata[DIV_W-1:0]; upper bits read 0.
  - 3 CTRL: R/W, [0] enable; reset value 1.
- Writing 1 to STATUS[3] clears overflow; all other STATUS write bits are ignored.
- Reset values: tx=1, FSM=IDLE, FIFO empty, overflow=0, BAUD_DIV=DEFAULT_DIV, enable=1. Reset mid-frame aborts the frame immediately; tx=1 asynchronously.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if enable && !empty, pop the FIFO head into the shift register, latch BAUD_DIV into the bit counter, go to START.
  - START: tx=0 for BAUD_DIV+1 cycles.
  - DATA: 8 bits, LSB first, each BAUD_DIV+1 cycles; a 3-bit index counts 0..7.
  - STOP: tx=1 for BAUD_DIV+1 cycles. At the end, if enable && !empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- tx is registered (no glitches). The frame is exactly 10 bit periods.
- BAUD_DIV is sampled only at pop. A write mid-frame takes effect on the next frame.
- BAUD_DIV=0 is legal: 1 cycle per bit.
- Latency: a TXDATA write at edge N into an empty FIFO with FSM IDLE gives a pop at edge N+1, and tx falls after edge N+1.
- Push while full and no pop in the same cycle: data is dropped, FIFO is unchanged, overflow is set.
- Push and pop in the same cycle while full: both are accepted; count is unchanged, no overflow.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- enable cleared mid-frame: the current frame completes, then the FSM holds IDLE. FIFO contents are retained; resumes when enable=1.
- Reads have no side effects. The CPU core issues no distinct read strobe, so reads must never pop.

Decomposition:
- uart_pkg: state enum (IDLE, START, DATA, STOP); register index constants REG_TXDATA=0, REG_STATUS=1, REG_BAUD=2, REG_CTRL=3; STATUS bit position constants.
- Sub-module fifo_sync:
  - Parameters WIDTH, DEPTH.
  - Ports clk, reset, push, pop, din, dout, full, empty, count.
  - Registered pointers; dout shows the head combinationally.
- uart_tx_slave contains the register decode, baud counter and FSM.

Test Plan:
- Reset, then read STATUS -> 0x0000_0002 (empty=1); BAUD_DIV reads 99; CTRL reads 1; tx=1.
- BAUD_DIV=9, write TXDATA=0x55 at edge N -> tx=0 on cycles N+1..N+10; then 1,0,1,0,1,0,1,0 for 10 cycles each; stop high 10 cycles; busy clears at N+101.
- BAUD_DIV=0, write 0xA3 then 0x0F on consecutive cycles -> two back-to-back 10-cycle frames, no idle gap; second start bit begins the cycle after the first stop bit.
- enable=0, write 9 bytes 0x01..0x09 -> STATUS: full=1, count=8, overflow=1; tx stays 1. Write STATUS=0x8 -> overflow=0. Set enable=1 -> bytes 0x01..0x08 transmit in order.
- Assert reset mid-DATA bit 3 -> tx=1 immediately; FIFO empty, STATUS=0x2. No residual frame after reset release.
- With ce=0, write to TXDATA -> no push; rdata=0.
